int_to_fp_converter: RTL

- Multi-cycle converter from 32-bit integer (signed or unsigned) to IEEE-754 single precision.
- Inverse of the float-to-integer rounding path.
- Serves CVT.S.W / CVT.S.WU in the FPU.
- Normalizes iteratively with a left-shift loop, then rounds to nearest-even and packs.
- Uses a start/busy/done handshake toward the FPU control FSM.

---
 rtl/fp_consts.sv | 22 ++
 rtl/fp_round_pack.sv | 44 ++++
 rtl/int_to_fp_converter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fp_consts.sv
// fp_consts: shared IEEE-754 single-precision constants and converter state encoding.
// Revision: 1.0
`default_nettype none

package fp_consts;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;

    // Exponent of a value whose leading one sits at bit 31 (bias + 31).
    localparam logic [FP_EXP_W-1:0] FP_INT_EXP_INIT = 8'd158;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        NORMALIZE = 2'd1,
        ROUND     = 2'd2
    } i2f_state_t;

endpackage

`default_nettype wire

// File: rtl/fp_round_pack.sv
// fp_round_pack: rounds a left-justified 32-bit magnitude to 24 bits (RNE or truncate) and packs a float.
// Revision: 1.0
`default_nettype none

module fp_round_pack
    import fp_consts::*;
(
    input  logic                sign,
    input  logic [FP_EXP_W-1:0] exp,
    input  logic [31:0]         mag,
    input  logic                rtz,
    output logic [31:0]         packed_fp,
    output logic                inexact
);

    logic [FP_MANT_W-1:0] w_m;
    logic [FP_MANT_W-1:0] w_mant;
    logic [FP_EXP_W-1:0]  w_exp;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_up;
    logic                 w_carry;

    always_comb begin
        w_m      = mag[30:8];
        w_guard  = mag[7];
        w_sticky = |mag[6:0];
        w_up     = ~rtz & w_guard & (w_sticky | w_m[0]);
        {w_carry, w_mant} = {1'b0, w_m} + {{FP_MANT_W{1'b0}}, w_up};
        w_exp    = w_carry ? exp + 8'd1 : exp;

        // A magnitude without its leading one is zero: emit a signed zero.
        if (!mag[31]) begin
            packed_fp = {sign, 31'd0};
            inexact   = 1'b0;
        end else begin
            packed_fp = {sign, w_exp, w_mant};
            inexact   = w_guard | w_sticky;
        end
    end

endmodule

`default_nettype wire

// File: rtl/int_to_fp_converter.sv
// int_to_fp_converter: multi-cycle 32-bit int/uint to IEEE-754 single conversion (CVT.S.W / CVT.S.WU).
// Optional macro INT_TO_FP_RTZ_EN adds a round_to_zero input. Revision: 1.0
`default_nettype none

module int_to_fp_converter
    import fp_consts::*;
#(
    parameter int NORM_STEP = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_signed,
`ifdef INT_TO_FP_RTZ_EN
    input  logic        round_to_zero,
`endif
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        inexact,
    output logic        busy,
    output logic        done
);

    i2f_state_t          r_state;
    logic                r_sign;
    logic [31:0]         r_mag;
    logic [FP_EXP_W-1:0] r_exp;
    logic                r_rtz;
    logic [31:0]         r_out;
    logic                r_inexact;
    logic                r_busy;
    logic                r_done;

    logic                w_sign;
    logic [31:0]         w_mag;
    logic                w_rtz;
    logic [31:0]         w_packed;
    logic                w_inexact;

    assign w_sign = is_signed & in[31];
    // Two's-complement negate; 0x80000000 maps onto itself as an unsigned magnitude.
    assign w_mag  = w_sign ? (~in) + 32'd1 : in;

`ifdef INT_TO_FP_RTZ_EN
    assign w_rtz = round_to_zero;
`else
    assign w_rtz = 1'b0;
`endif

    fp_round_pack u_round_pack (
        .sign      (r_sign),
        .exp       (r_exp),
        .mag       (r_mag),
        .rtz       (r_rtz),
        .packed_fp (w_packed),
        .inexact   (w_inexact)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_sign    <= 1'b0;
            r_mag     <= 32'd0;
            r_exp     <= 8'd0;
            r_rtz     <= 1'b0;
            r_out     <= 32'd0;
            r_inexact <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign <= w_sign;
                        r_mag  <= w_mag;
                        r_exp  <= FP_INT_EXP_INIT;
                        r_rtz  <= w_rtz;
                        if (in == 32'd0) begin
                            r_out     <= 32'd0;
                            r_inexact <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state <= NORMALIZE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                NORMALIZE: begin
                    if (r_mag[31]) begin
                        r_state <= ROUND;
                    end else if (r_mag[31 -: NORM_STEP] == '0) begin
                        r_mag <= r_mag << NORM_STEP;
                        r_exp <= r_exp - 8'(NORM_STEP);
                    end else begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 8'd1;
                    end
                end
                ROUND: begin
                    r_out     <= w_packed;
                    r_inexact <= w_inexact;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out     = r_out;
    assign inexact = r_inexact;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

`default_nettype wire
